atm_session_tx: RTL and testbench

Host-side session sequencer that drives the ATM controller's customer-input protocol: card presence, one PIN digit per strobe, transaction type and amount. It then waits for the controller's verdict and returns a single result code to the host. It sits between the keypad/host front end and the ATM controller, as the transmitting end of the controller's digit/amount strobe interface.

---
 rtl/atm_pkg.sv | 49 ++++
 rtl/atm_verdict_enc.sv | 44 ++++
 rtl/atm_session_tx.sv | 249 ++++++++++++++++++++++++
 tb/tb_atm_session_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// ---------------------------------------------------------------------------
// atm_pkg
// Shared definitions for the ATM host-side session sequencer:
//   - state_t      : session sequencer states
//   - RES_*        : 3-bit result codes returned to the host
//   - BCD_W        : width of one PIN digit
//   - PIN_DIGITS   : number of digits in a PIN
//   - pin_digit()  : selects digit[idx] of a packed PIN, digit 0 in the MSBs
// ---------------------------------------------------------------------------
package atm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CARD,
        DIGIT,
        GAP,
        AMOUNT,
        RESP_WAIT,
        RELEASE
    } state_t;

    localparam logic [2:0] RES_NONE        = 3'd0;
    localparam logic [2:0] RES_DEPOSIT_OK  = 3'd1;
    localparam logic [2:0] RES_WITHDRAW_OK = 3'd2;
    localparam logic [2:0] RES_NO_FUNDS    = 3'd3;
    localparam logic [2:0] RES_BAD_PIN     = 3'd4;
    localparam logic [2:0] RES_BLOCKED     = 3'd5;
    localparam logic [2:0] RES_TIMEOUT     = 3'd6;
    localparam logic [2:0] RES_ABORT       = 3'd7;

    localparam int BCD_W      = 4;
    localparam int PIN_DIGITS = 4;

    // Digit 0 is the first one keyed in and lives in the most significant nibble.
    function automatic logic [BCD_W-1:0] pin_digit(
        input logic [BCD_W*PIN_DIGITS-1:0] pin,
        input logic [1:0]                  idx
    );
        logic [BCD_W-1:0] d;
        case (idx)
            2'd0:    d = pin[15:12];
            2'd1:    d = pin[11:8];
            2'd2:    d = pin[7:4];
            default: d = pin[3:0];
        endcase
        return d;
    endfunction

endpackage

// File: rtl/atm_verdict_enc.sv
// ---------------------------------------------------------------------------
// atm_verdict_enc
// Combinational priority encoder for the ATM controller's verdict lines.
// Ports:
//   bloqueo, pin_incorrecto, fondos_insuficientes,
//   entregar_dinero, balance_actualizado : verdict inputs from the controller
//   tipo_trans : latched transaction type (1 = deposit, 0 = withdrawal)
//   valid      : at least one verdict applies to this transaction
//   code       : result code of the highest-priority applicable verdict
// ---------------------------------------------------------------------------
module atm_verdict_enc
    import atm_pkg::*;
(
    input  logic       bloqueo,
    input  logic       pin_incorrecto,
    input  logic       fondos_insuficientes,
    input  logic       entregar_dinero,
    input  logic       balance_actualizado,
    input  logic       tipo_trans,
    output logic       valid,
    output logic [2:0] code
);

    // Success verdicts only count when they match the transaction type;
    // a mismatched one falls through as if it were not asserted.
    always_comb begin
        valid = 1'b1;
        code  = RES_NONE;
        if (bloqueo) begin
            code = RES_BLOCKED;
        end else if (pin_incorrecto) begin
            code = RES_BAD_PIN;
        end else if (fondos_insuficientes) begin
            code = RES_NO_FUNDS;
        end else if (entregar_dinero && !tipo_trans) begin
            code = RES_WITHDRAW_OK;
        end else if (balance_actualizado && tipo_trans) begin
            code = RES_DEPOSIT_OK;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/atm_session_tx.sv
// ---------------------------------------------------------------------------
// atm_session_tx
// Host-side session sequencer driving the ATM controller's customer-input
// protocol: card presence, four PIN digits (one per strobe), transaction
// type and amount, then waits for a verdict and reports one result code.
// Parameters:
//   DIGIT_GAP    : idle cycles after each digit strobe (1..15)
//   RESP_TIMEOUT : response wait limit in cycles (1..1023)
// Ports:
//   clk, reset (async, active-low)
//   start, abort                 : host requests
//   card_type_in, pin_in, trans_type_in, amount_in : session data, latched on start
//   balance_actualizado, entregar_dinero, fondos_insuficientes,
//   pin_incorrecto, bloqueo      : verdicts from the controller
//   tarjeta_recibida, tipo_de_tarjeta, digito, digito_stb,
//   tipo_trans, monto, monto_stb : controller-side strobe interface
//   busy, done, result           : host status
// ---------------------------------------------------------------------------
module atm_session_tx
    import atm_pkg::*;
#(
    parameter int DIGIT_GAP    = 3,
    parameter int RESP_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        card_type_in,
    input  logic [15:0] pin_in,
    input  logic        trans_type_in,
    input  logic [31:0] amount_in,
    input  logic        balance_actualizado,
    input  logic        entregar_dinero,
    input  logic        fondos_insuficientes,
    input  logic        pin_incorrecto,
    input  logic        bloqueo,
    output logic        tarjeta_recibida,
    output logic        tipo_de_tarjeta,
    output logic [3:0]  digito,
    output logic        digito_stb,
    output logic        tipo_trans,
    output logic [31:0] monto,
    output logic        monto_stb,
    output logic        busy,
    output logic        done,
    output logic [2:0]  result
);

    localparam logic [3:0] GAP_LAST   = 4'(DIGIT_GAP - 1);
    localparam logic [9:0] WAIT_LIMIT = 10'(RESP_TIMEOUT);
    localparam logic [1:0] LAST_DIGIT = 2'(PIN_DIGITS - 1);

    state_t                        state_q, state_d;
    logic [1:0]                    idx_q, idx_d;
    logic [3:0]                    gap_cnt_q, gap_cnt_d;
    logic [9:0]                    wait_cnt_q, wait_cnt_d;
    logic [BCD_W*PIN_DIGITS-1:0]   pin_q, pin_d;

    logic        tarjeta_recibida_q, tarjeta_recibida_d;
    logic        tipo_de_tarjeta_q, tipo_de_tarjeta_d;
    logic [3:0]  digito_q, digito_d;
    logic        digito_stb_q, digito_stb_d;
    logic        tipo_trans_q, tipo_trans_d;
    logic [31:0] monto_q, monto_d;
    logic        monto_stb_q, monto_stb_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [2:0]  result_q, result_d;

    logic        verdict_valid;
    logic [2:0]  verdict_code;
    logic        early_hit;
    logic        go_release;
    logic [2:0]  release_code;

    atm_verdict_enc u_verdict_enc (
        .bloqueo              (bloqueo),
        .pin_incorrecto       (pin_incorrecto),
        .fondos_insuficientes (fondos_insuficientes),
        .entregar_dinero      (entregar_dinero),
        .balance_actualizado  (balance_actualizado),
        .tipo_trans           (tipo_trans_q),
        .valid                (verdict_valid),
        .code                 (verdict_code)
    );

    // Before the response window only the PIN/lock verdicts can end a
    // session; the encoder already ranks them above everything else.
    assign early_hit = bloqueo | pin_incorrecto;

    // Outputs are registered and set on the edge that enters a state, so
    // each strobe lines up with the cycle its state is current.
    always_comb begin
        state_d            = state_q;
        idx_d              = idx_q;
        gap_cnt_d          = gap_cnt_q;
        wait_cnt_d         = wait_cnt_q;
        pin_d              = pin_q;
        tarjeta_recibida_d = tarjeta_recibida_q;
        tipo_de_tarjeta_d  = tipo_de_tarjeta_q;
        digito_d           = digito_q;
        digito_stb_d       = 1'b0;
        tipo_trans_d       = tipo_trans_q;
        monto_d            = monto_q;
        monto_stb_d        = 1'b0;
        busy_d             = busy_q;
        done_d             = 1'b0;
        result_d           = result_q;
        go_release         = 1'b0;
        release_code       = RES_NONE;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pin_d              = pin_in;
                    tipo_de_tarjeta_d  = card_type_in;
                    tipo_trans_d       = trans_type_in;
                    monto_d            = amount_in;
                    busy_d             = 1'b1;
                    result_d           = RES_NONE;
                    tarjeta_recibida_d = 1'b1;
                    state_d            = CARD;
                end
            end

            CARD, DIGIT, GAP, AMOUNT: begin
                if (early_hit) begin
                    go_release   = 1'b1;
                    release_code = verdict_code;
                end else if (abort) begin
                    go_release   = 1'b1;
                    release_code = RES_ABORT;
                end else begin
                    case (state_q)
                        CARD: begin
                            idx_d        = 2'd0;
                            digito_d     = pin_digit(pin_q, 2'd0);
                            digito_stb_d = 1'b1;
                            state_d      = DIGIT;
                        end
                        DIGIT: begin
                            gap_cnt_d = 4'd0;
                            state_d   = GAP;
                        end
                        GAP: begin
                            if (gap_cnt_q == GAP_LAST) begin
                                if (idx_q == LAST_DIGIT) begin
                                    monto_stb_d = 1'b1;
                                    state_d     = AMOUNT;
                                end else begin
                                    idx_d        = idx_q + 2'd1;
                                    digito_d     = pin_digit(pin_q, idx_q + 2'd1);
                                    digito_stb_d = 1'b1;
                                    state_d      = DIGIT;
                                end
                            end else begin
                                gap_cnt_d = gap_cnt_q + 4'd1;
                            end
                        end
                        default: begin
                            wait_cnt_d = 10'd0;
                            state_d    = RESP_WAIT;
                        end
                    endcase
                end
            end

            RESP_WAIT: begin
                if (verdict_valid) begin
                    go_release   = 1'b1;
                    release_code = verdict_code;
                end else if (abort) begin
                    go_release   = 1'b1;
                    release_code = RES_ABORT;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    go_release   = 1'b1;
                    release_code = RES_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 10'd1;
                end
            end

            RELEASE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (go_release) begin
            tarjeta_recibida_d = 1'b0;
            done_d             = 1'b1;
            result_d           = release_code;
            state_d            = RELEASE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q            <= IDLE;
            idx_q              <= 2'd0;
            gap_cnt_q          <= 4'd0;
            wait_cnt_q         <= 10'd0;
            pin_q              <= '0;
            tarjeta_recibida_q <= 1'b0;
            tipo_de_tarjeta_q  <= 1'b0;
            digito_q           <= 4'd0;
            digito_stb_q       <= 1'b0;
            tipo_trans_q       <= 1'b0;
            monto_q            <= 32'd0;
            monto_stb_q        <= 1'b0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            result_q           <= RES_NONE;
        end else begin
            state_q            <= state_d;
            idx_q              <= idx_d;
            gap_cnt_q          <= gap_cnt_d;
            wait_cnt_q         <= wait_cnt_d;
            pin_q              <= pin_d;
            tarjeta_recibida_q <= tarjeta_recibida_d;
            tipo_de_tarjeta_q  <= tipo_de_tarjeta_d;
            digito_q           <= digito_d;
            digito_stb_q       <= digito_stb_d;
            tipo_trans_q       <= tipo_trans_d;
            monto_q            <= monto_d;
            monto_stb_q        <= monto_stb_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
            result_q           <= result_d;
        end
    end

    assign tarjeta_recibida = tarjeta_recibida_q;
    assign tipo_de_tarjeta  = tipo_de_tarjeta_q;
    assign digito           = digito_q;
    assign digito_stb       = digito_stb_q;
    assign tipo_trans       = tipo_trans_q;
    assign monto            = monto_q;
    assign monto_stb        = monto_stb_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign result           = result_q;

endmodule

// File: tb/tb_atm_session_tx.sv
// ---------------------------------------------------------------------------
// tb_atm_session_tx
// Self-checking bench for atm_session_tx. Each session is described by its
// data, one verdict pulse, an optional abort, an optional stray start and an
// optional mid-session reset. The expected end cycle and result code come
// from a timeline model of the session (strobe cycles from the timing
// formulas, verdict/abort/timeout rules), and observed strobes are compared
// against it. Cycle numbers count edges after the edge that samples start.
// ---------------------------------------------------------------------------
module tb_atm_session_tx;

    localparam int G  = 3;
    localparam int T  = 8;
    localparam int A  = 2 + 4 * (G + 1);
    localparam int M  = A + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        card_type_in;
    logic [15:0] pin_in;
    logic        trans_type_in;
    logic [31:0] amount_in;
    logic        balance_actualizado;
    logic        entregar_dinero;
    logic        fondos_insuficientes;
    logic        pin_incorrecto;
    logic        bloqueo;
    logic        tarjeta_recibida;
    logic        tipo_de_tarjeta;
    logic [3:0]  digito;
    logic        digito_stb;
    logic        tipo_trans;
    logic [31:0] monto;
    logic        monto_stb;
    logic        busy;
    logic        done;
    logic [2:0]  result;

    int compareCount  = 0;
    int mismatchCount = 0;

    always #5 clk = ~clk;

    atm_session_tx #(.DIGIT_GAP(G), .RESP_TIMEOUT(T)) dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .abort                (abort),
        .card_type_in         (card_type_in),
        .pin_in               (pin_in),
        .trans_type_in        (trans_type_in),
        .amount_in            (amount_in),
        .balance_actualizado  (balance_actualizado),
        .entregar_dinero      (entregar_dinero),
        .fondos_insuficientes (fondos_insuficientes),
        .pin_incorrecto       (pin_incorrecto),
        .bloqueo              (bloqueo),
        .tarjeta_recibida     (tarjeta_recibida),
        .tipo_de_tarjeta      (tipo_de_tarjeta),
        .digito               (digito),
        .digito_stb           (digito_stb),
        .tipo_trans           (tipo_trans),
        .monto                (monto),
        .monto_stb            (monto_stb),
        .busy                 (busy),
        .done                 (done),
        .result               (result)
    );

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] allOutputs();
        return 64'({tarjeta_recibida, tipo_de_tarjeta, digito, digito_stb, tipo_trans,
                    monto, monto_stb, busy, done, result});
    endfunction

    // Timeline model: walk the session cycle by cycle. Before the response
    // window (cycle M) only bloqueo/pin_incorrecto/abort end it; inside the
    // window all verdicts apply (success ones only if they match the
    // transaction), then abort, then the timeout at M+T. The session ends
    // (done) one cycle after the deciding edge.
    function automatic void modelSession(input bit tipo, input int evCyc, input bit [4:0] evBits,
                                         input int abCyc, output int dCyc, output int code);
        dCyc = 0;
        code = 0;
        for (int c = 1; c <= M + T; c++) begin
            int got;
            bit ev;
            got = 0;
            ev  = (c == evCyc);
            if (ev && evBits[4])                        got = 5;
            else if (ev && evBits[3])                   got = 4;
            else if (c >= M && ev && evBits[2])         got = 3;
            else if (c >= M && ev && evBits[1] && !tipo) got = 2;
            else if (c >= M && ev && evBits[0] && tipo)  got = 1;
            else if (c == abCyc)                        got = 7;
            else if (c == M + T)                        got = 6;
            if (got != 0) begin
                dCyc = c + 1;
                code = got;
                return;
            end
        end
    endfunction

    // Runs one session. evBits = {bloqueo, pin_incorrecto, fondos, entregar, balance}.
    task automatic applyStimulus(input string name, input bit tipo, input bit card,
                                 input logic [15:0] pin, input logic [31:0] amt,
                                 input int evCyc, input bit [4:0] evBits, input int abCyc,
                                 input int st2Cyc, input int rstCyc);
        int dExp, codeExp, nExp, dObs, mCount, mCyc;
        int cardBad, busyBad, stbBad;
        int dgCyc[$];
        logic [3:0] dgVal[$];
        logic [31:0] mVal;
        logic mTipo, prevStb, cardType1, cardAtDone, wasReset;
        logic [2:0] resAtDone, res1;
        logic [15:0] sh;

        modelSession(tipo, evCyc, evBits, abCyc, dExp, codeExp);
        if (st2Cyc >= dExp) st2Cyc = 0;
        nExp = 0;
        for (int k = 0; k < 4; k++) if (2 + k * (G + 1) < dExp) nExp++;

        dObs = 0; mCount = 0; mCyc = 0; mVal = '0; mTipo = 1'b0;
        cardBad = 0; busyBad = 0; stbBad = 0; prevStb = 1'b0; wasReset = 1'b0;
        cardType1 = 1'b0; res1 = '0; resAtDone = '0; cardAtDone = 1'b0;

        start = 1'b1; card_type_in = card; pin_in = pin; trans_type_in = tipo; amount_in = amt;
        @(posedge clk); #1;
        start = 1'b0;
        pin_in = 16'($urandom); amount_in = $urandom;
        card_type_in = ~card; trans_type_in = ~tipo;

        for (int c = 1; c <= M + T + 6; c++) begin
            if (c == rstCyc) begin
                reset = 1'b0;
                #1;
                checkOutput({name, ":outputs_in_reset"}, allOutputs(), 64'd0);
                #2;
                reset = 1'b1;
                start = 1'b0; abort = 1'b0;
                {bloqueo, pin_incorrecto, fondos_insuficientes, entregar_dinero, balance_actualizado} = 5'd0;
                @(posedge clk); #1;
                checkOutput({name, ":idle_after_reset"}, 64'({busy, done, tarjeta_recibida, digito_stb}), 64'd0);
                wasReset = 1'b1;
                break;
            end
            if (c == 1) begin
                cardType1 = tipo_de_tarjeta;
                res1      = result;
            end
            if (digito_stb) begin
                dgCyc.push_back(c);
                dgVal.push_back(digito);
            end
            if (monto_stb) begin
                mCount++; mCyc = c; mVal = monto; mTipo = tipo_trans;
            end
            if ((digito_stb || monto_stb) && (prevStb || (digito_stb && monto_stb))) stbBad++;
            prevStb = digito_stb | monto_stb;
            if (done) begin
                dObs = c; resAtDone = result; cardAtDone = tarjeta_recibida;
                break;
            end
            if (!tarjeta_recibida) cardBad++;
            if (!busy) busyBad++;
            start = (c == st2Cyc);
            if (c == st2Cyc) begin
                pin_in = ~pin; amount_in = ~amt; trans_type_in = ~tipo; card_type_in = ~card;
            end
            abort = (c == abCyc);
            {bloqueo, pin_incorrecto, fondos_insuficientes, entregar_dinero, balance_actualizado} =
                (c == evCyc) ? evBits : 5'd0;
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0;
        {bloqueo, pin_incorrecto, fondos_insuficientes, entregar_dinero, balance_actualizado} = 5'd0;

        if (!wasReset) begin
            checkOutput({name, ":done_cycle"}, 64'(dObs), 64'(dExp));
            checkOutput({name, ":digit_count"}, 64'(dgCyc.size()), 64'(nExp));
            for (int k = 0; k < dgCyc.size() && k < nExp; k++) begin
                sh = pin >> (12 - 4 * k);
                checkOutput($sformatf("%s:digit%0d_cycle", name, k), 64'(dgCyc[k]), 64'(2 + k * (G + 1)));
                checkOutput($sformatf("%s:digit%0d_value", name, k), 64'(dgVal[k]), 64'(sh[3:0]));
            end
            checkOutput({name, ":monto_count"}, 64'(mCount), (A < dExp) ? 64'd1 : 64'd0);
            if (mCount == 1 && A < dExp) begin
                checkOutput({name, ":monto_cycle"}, 64'(mCyc), 64'(A));
                checkOutput({name, ":monto_value"}, 64'(mVal), 64'(amt));
                checkOutput({name, ":tipo_trans"}, 64'(mTipo), 64'(tipo));
            end
            checkOutput({name, ":result"}, 64'(resAtDone), 64'(codeExp));
            checkOutput({name, ":card_at_done"}, 64'(cardAtDone), 64'd0);
            checkOutput({name, ":card_held"}, 64'(cardBad), 64'd0);
            checkOutput({name, ":busy_held"}, 64'(busyBad), 64'd0);
            checkOutput({name, ":strobe_rule"}, 64'(stbBad), 64'd0);
            checkOutput({name, ":card_type"}, 64'(cardType1), 64'(card));
            checkOutput({name, ":result_cleared"}, 64'(res1), 64'd0);
            if (dObs == 0) begin
                // Session never finished; force it back to idle.
                reset = 1'b0; #2; reset = 1'b1;
                @(posedge clk); #1;
            end else begin
                @(posedge clk); #1;
                checkOutput({name, ":busy_after"}, 64'(busy), 64'd0);
                checkOutput({name, ":result_held"}, 64'(result), 64'(codeExp));
            end
        end
    endtask

    initial begin
        bit tipo, card;
        bit [4:0] evBits;
        int evCyc, abCyc, st2Cyc;

        reset = 1'b0; start = 1'b0; abort = 1'b0;
        card_type_in = 1'b0; pin_in = '0; trans_type_in = 1'b0; amount_in = '0;
        {bloqueo, pin_incorrecto, fondos_insuficientes, entregar_dinero, balance_actualizado} = 5'd0;
        #1;
        checkOutput("reset_state", allOutputs(), 64'd0);
        #11;
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed sessions.
        applyStimulus("deposit",        1'b1, 1'b1, 16'h1234, 32'd500,  A + 5, 5'b00001, 0, 0, 0);
        applyStimulus("funds_vs_cash",  1'b0, 1'b0, 16'h9876, 32'd200,  M + 2, 5'b00110, 0, 0, 0);
        applyStimulus("wrong_pin",      1'b0, 1'b1, 16'h4321, 32'd77,   7,     5'b01000, 0, 0, 0);
        applyStimulus("timeout",        1'b1, 1'b0, 16'h5555, 32'd1000, 0,     5'b00000, 0, 0, 0);
        applyStimulus("mismatch",       1'b1, 1'b1, 16'h2468, 32'd9,    M + 3, 5'b00010, 0, 0, 0);
        applyStimulus("abort",          1'b0, 1'b0, 16'h1357, 32'd42,   0,     5'b00000, 5, 0, 0);
        applyStimulus("abort_bloqueo",  1'b0, 1'b1, 16'h8642, 32'd43,   6,     5'b10000, 6, 0, 0);
        applyStimulus("abort_in_wait",  1'b1, 1'b0, 16'h0909, 32'd44,   0,     5'b00000, M + 4, 0, 0);
        applyStimulus("restart_ignore", 1'b1, 1'b1, 16'h3141, 32'd600,  A + 2, 5'b00001, 0, 4, 0);
        applyStimulus("reset_mid",      1'b0, 1'b1, 16'h7777, 32'd5,    0,     5'b00000, 0, 0, 9);
        applyStimulus("after_reset",    1'b0, 1'b0, 16'h2718, 32'd300,  M,     5'b00010, 0, 0, 0);

        // Randomized sessions.
        for (int i = 0; i < 40; i++) begin
            tipo      = 1'($urandom_range(0, 1));
            card      = 1'($urandom_range(0, 1));
            evCyc     = int'($urandom_range(1, M + T + 1));
            evBits[4] = ($urandom_range(0, 7) == 0);
            evBits[3] = ($urandom_range(0, 7) == 0);
            evBits[2] = ($urandom_range(0, 2) == 0);
            evBits[1] = ($urandom_range(0, 2) == 0);
            evBits[0] = ($urandom_range(0, 2) == 0);
            abCyc     = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, M + T)) : 0;
            st2Cyc    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            applyStimulus($sformatf("rand%0d", i), tipo, card, 16'($urandom), $urandom,
                          evCyc, evBits, abCyc, st2Cyc, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
